// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial sequence generator and detector blocks.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic IDLE_BIT_DEF = 1'b0;

  // Width of a length field able to hold 0..pat_w
  function automatic int unsigned len_w(input int unsigned pat_w);
    return $clog2(pat_w) + 1;
  endfunction

endpackage

// File: rtl/seq_pattern_cnt.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
module seq_pattern_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern generator: sends a latched pattern MSB-first, rpt+1 times,
// with gap idle cycles between repetitions.
module seq_pattern_tx
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W    = 8,
  parameter int unsigned CNT_W    = 4,
  parameter logic        IDLE_BIT = IDLE_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic                      ready,
  input  logic [PAT_W-1:0]          pattern,
  input  logic [len_w(PAT_W)-1:0]   len,
  input  logic [CNT_W-1:0]          rpt,
  input  logic [CNT_W-1:0]          gap,
  input  logic                      abort,
  output logic                      out,
  output logic                      out_vld,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned LW = len_w(PAT_W);

  state_e           r_state, w_state_n;
  logic [PAT_W-1:0] r_pat;
  logic [LW-1:0]    r_len;
  logic [CNT_W-1:0] r_gap;
  logic             r_out, r_vld, r_done, r_err;

  logic             w_out_n, w_vld_n, w_done_n, w_err_n;
  logic [LW-1:0]    w_len_eff;
  logic             w_accept;
  logic             w_first;

  logic             w_b_load, w_b_dec, w_b_zero;
  logic [LW-1:0]    w_b_val, w_bcnt;
  logic             w_r_load, w_r_dec, w_r_zero;
  logic [CNT_W-1:0] w_rcnt;
  logic             w_g_load, w_g_dec, w_g_zero;
  logic [CNT_W-1:0] w_g_val, w_gcnt;

  function automatic logic pick(input logic [PAT_W-1:0] p, input logic [LW-1:0] idx);
    logic [PAT_W-1:0] sh;
    sh = p >> idx;
    return sh[0];
  endfunction

  assign w_len_eff = (len > LW'(PAT_W)) ? LW'(PAT_W) : len;
  assign w_accept  = (r_state == IDLE) && start && !abort && (len != '0);
  assign w_first   = pick(r_pat, r_len - LW'(1));

  // bit index, remaining repetitions, remaining gap cycles
  seq_pattern_cnt #(.W(LW)) u_bit_cnt (
    .clk(clk), .rstn(rstn), .i_load(w_b_load), .i_val(w_b_val),
    .i_dec(w_b_dec), .o_cnt(w_bcnt), .o_zero(w_b_zero)
  );

  seq_pattern_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk(clk), .rstn(rstn), .i_load(w_r_load), .i_val(rpt),
    .i_dec(w_r_dec), .o_cnt(w_rcnt), .o_zero(w_r_zero)
  );

  seq_pattern_cnt #(.W(CNT_W)) u_gap_cnt (
    .clk(clk), .rstn(rstn), .i_load(w_g_load), .i_val(w_g_val),
    .i_dec(w_g_dec), .o_cnt(w_gcnt), .o_zero(w_g_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state plus the values the output registers take at the coming edge
  always_comb begin
    w_state_n = r_state;
    w_out_n   = IDLE_BIT;
    w_vld_n   = 1'b0;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_b_load  = 1'b0;
    w_b_val   = r_len - LW'(1);
    w_b_dec   = 1'b0;
    w_r_load  = 1'b0;
    w_r_dec   = 1'b0;
    w_g_load  = 1'b0;
    w_g_val   = r_gap - CNT_W'(1);
    w_g_dec   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if (len == '0) begin
            w_err_n = 1'b1;
          end else begin
            w_state_n = SHIFT;
            w_b_load  = 1'b1;
            w_b_val   = w_len_eff - LW'(1);
            w_r_load  = 1'b1;
            w_out_n   = pick(pattern, w_len_eff - LW'(1));
            w_vld_n   = 1'b1;
            w_done_n  = (w_len_eff == LW'(1)) && (rpt == '0);
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          w_state_n = IDLE;
        end else if (!w_b_zero) begin
          w_b_dec  = 1'b1;
          w_out_n  = pick(r_pat, w_bcnt - LW'(1));
          w_vld_n  = 1'b1;
          w_done_n = (w_bcnt == LW'(1)) && w_r_zero;
        end else if (w_r_zero) begin
          w_state_n = IDLE;
        end else begin
          w_r_dec = 1'b1;
          if (r_gap != '0) begin
            w_state_n = GAP;
            w_g_load  = 1'b1;
          end else begin
            // back-to-back repetition: next first bit follows with no bubble
            w_b_load = 1'b1;
            w_out_n  = w_first;
            w_vld_n  = 1'b1;
            w_done_n = (r_len == LW'(1)) && (w_rcnt == CNT_W'(1));
          end
        end
      end
      GAP: begin
        if (abort) begin
          w_state_n = IDLE;
        end else if (w_g_zero) begin
          w_state_n = SHIFT;
          w_b_load  = 1'b1;
          w_out_n   = w_first;
          w_vld_n   = 1'b1;
          w_done_n  = (r_len == LW'(1)) && w_r_zero;
        end else begin
          w_g_dec = (w_gcnt != '0);
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out  <= IDLE_BIT;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_pat  <= '0;
      r_len  <= '0;
      r_gap  <= '0;
    end else begin
      r_out  <= w_out_n;
      r_vld  <= w_vld_n;
      r_done <= w_done_n;
      r_err  <= w_err_n;
      if (w_accept) begin
        r_pat <= pattern;
        r_len <= w_len_eff;
        r_gap <= gap;
      end
    end
  end

  assign ready   = (r_state == IDLE);
  assign out     = r_out;
  assign out_vld = r_vld;
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: vector table of whole transfers plus
// hand-written abort, reject, retrigger and reset sequences.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, abort;
  logic [7:0] pattern;
  logic [3:0] len, rpt, gap;
  logic       ready, out, out_vld, done, err;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [3:0]  rpt;
    logic [3:0]  gap;
    int          n;
    logic [31:0] eout;
    logic [31:0] evld;
  } vec_t;

  vec_t tbl [7];

  seq_pattern_tx dut (
    .clk(clk), .rstn(rstn), .start(start), .ready(ready),
    .pattern(pattern), .len(len), .rpt(rpt), .gap(gap), .abort(abort),
    .out(out), .out_vld(out_vld), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign obs = {out, out_vld, done, err, ready};

  initial begin
    #500000;
    $display("FAIL watchdog obs=%b", obs);
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s {out,vld,done,err,ready} got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready got=%b want=1", ready);
    end
  endtask

  task automatic run_vec(input int id);
    vec_t v;
    v = tbl[id];
    wait_ready();
    pattern = v.pat; len = v.len; rpt = v.rpt; gap = v.gap; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    pattern = 8'($urandom);
    len     = 4'($urandom);
    rpt     = 4'($urandom);
    gap     = 4'($urandom);
    for (int i = 0; i < v.n; i++) begin
      int j;
      j = v.n - 1 - i;
      chk($sformatf("vec%0d_cyc%0d", id, i), obs,
          {v.eout[j], v.evld[j], (i == v.n - 1), 1'b0, 1'b0});
      @(negedge clk);
    end
    chk($sformatf("vec%0d_end", id), obs, 5'b00001);
  endtask

  task automatic send(input logic [7:0] p, input logic [3:0] l,
                      input logic [3:0] r, input logic [3:0] g);
    pattern = p; len = l; rpt = r; gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; rpt = '0; gap = '0;

    tbl[0] = '{8'h05, 4'd3,  4'd0, 4'd0, 3,  32'b101,                 32'b111};
    tbl[1] = '{8'h05, 4'd3,  4'd2, 4'd1, 11, 32'b10101010101,         32'b11101110111};
    tbl[2] = '{8'h05, 4'd3,  4'd2, 4'd0, 9,  32'b101101101,           32'b111111111};
    tbl[3] = '{8'hA5, 4'd12, 4'd0, 4'd0, 8,  32'b10100101,            32'b11111111};
    tbl[4] = '{8'h01, 4'd1,  4'd3, 4'd2, 10, 32'b1001001001,          32'b1001001001};
    tbl[5] = '{8'h00, 4'd1,  4'd1, 4'd0, 2,  32'b00,                  32'b11};
    tbl[6] = '{8'hC3, 4'd8,  4'd1, 4'd3, 19, 32'b1100001100011000011, 32'b1111111100011111111};

    #12;
    chk("reset_state", obs, 5'b00001);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset", obs, 5'b00001);

    for (int i = 0; i < 7; i++) run_vec(i);

    // len==0 is rejected with a one-cycle err pulse
    wait_ready();
    send(8'hFF, 4'd0, 4'd0, 4'd0);
    chk("len0_err", obs, 5'b00011);
    @(negedge clk);
    chk("len0_err_clear", obs, 5'b00001);

    // abort on the third bit, then start coincident with abort in IDLE is ignored
    send(8'hFF, 4'd8, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre", obs, 5'b11000);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_idle", obs, 5'b00001);
    pattern = 8'h05; len = 4'd3; rpt = 4'd0; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    chk("abort_blocks_start", obs, 5'b00001);
    abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("after_abort_b0", obs, 5'b11000);
    @(negedge clk);
    chk("after_abort_b1", obs, 5'b01000);
    @(negedge clk);
    chk("after_abort_b2", obs, 5'b11100);
    @(negedge clk);
    chk("after_abort_end", obs, 5'b00001);

    // start held high re-triggers on the first IDLE cycle
    pattern = 8'h05; len = 4'd3; rpt = 4'd0; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    chk("hold_b0", obs, 5'b11000);
    @(negedge clk);
    chk("hold_b1", obs, 5'b01000);
    @(negedge clk);
    chk("hold_b2", obs, 5'b11100);
    @(negedge clk);
    chk("hold_idle", obs, 5'b00001);
    @(negedge clk);
    start = 1'b0;
    chk("hold_retrig", obs, 5'b11000);
    wait_ready();

    // asynchronous reset mid-GAP and mid-SHIFT
    send(8'h05, 4'd3, 4'd2, 4'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("gap_before_rst", obs, 5'b00000);
    #2 rstn = 1'b0;
    #1 chk("rst_mid_gap", obs, 5'b00001);
    @(negedge clk);
    rstn = 1'b1;
    send(8'hFF, 4'd8, 4'd0, 4'd0);
    chk("shift_before_rst", obs, 5'b11000);
    #2 rstn = 1'b0;
    #1 chk("rst_mid_shift", obs, 5'b00001);
    @(negedge clk);
    rstn = 1'b1;
    send(8'h05, 4'd3, 4'd0, 4'd0);
    chk("rst_release_b0", obs, 5'b11000);
    @(negedge clk);
    chk("rst_release_b1", obs, 5'b01000);
    @(negedge clk);
    chk("rst_release_b2", obs, 5'b11100);
    @(negedge clk);
    chk("rst_release_end", obs, 5'b00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
